// File: rtl/flappy_pkg.sv
// Constants shared by the tube generator, game controller and VGA renderer.
package flappy_pkg;
    localparam int SCREEN_H = 480;
    localparam int SCREEN_W = 640;
    localparam int TUBE_W   = 40;
    localparam int GAP_H    = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;
endpackage

// File: rtl/tube_hit.sv
// Combinational overlap test of the bird square against one tube.
module tube_hit
    import flappy_pkg::*;
#(
    parameter int BIRD_X    = 160,
    parameter int BIRD_SIZE = 16
) (
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [9:0] bird_y,
    output logic       hit
);
    logic x_ovl, out_gap;

    // 11-bit sums so a tube near the right edge cannot wrap into view
    assign x_ovl   = ({1'b0, x_pos} < 11'(BIRD_X + BIRD_SIZE)) &&
                     ({1'b0, x_pos} + 11'(TUBE_W) > 11'(BIRD_X));
    assign out_gap = (bird_y < y_pos) ||
                     ({1'b0, bird_y} + 11'(BIRD_SIZE) > {1'b0, y_pos} + 11'(GAP_H));
    assign hit     = x_ovl && out_gap;
endmodule

// File: rtl/bird_game_ctrl.sv
// Bird physics, collision detection and IDLE/PLAY/DYING/OVER sequencing.
module bird_game_ctrl
    import flappy_pkg::*;
#(
    parameter int BIRD_X      = 160,
    parameter int BIRD_SIZE   = 16,
    parameter int Y_START     = 240,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = -8,
    parameter int VMAX        = 10,
    parameter int DEATH_TICKS = 20
) (
    input  logic       clk10,
    input  logic       clr_n,
    input  logic       flap,
    input  logic [9:0] tube1_x_pos,
    input  logic [9:0] tube2_x_pos,
    input  logic [9:0] tube3_x_pos,
    input  logic [9:0] tube1_y_pos,
    input  logic [9:0] tube2_y_pos,
    input  logic [9:0] tube3_y_pos,
    input  logic [7:0] score,
    output logic [9:0] bird_y,
    output logic [1:0] state,
    output logic       collide,
    output logic       tubes_run,
    output logic [7:0] best_score
);
    localparam int NUM_TUBES = 3;
    localparam int CNT_W     = $clog2(DEATH_TICKS + 1);
    localparam logic signed [5:0]  FLAP_V  = 6'(FLAP_VEL);
    localparam logic signed [5:0]  VMAX_V  = 6'(VMAX);
    localparam logic signed [5:0]  GRAV_V  = 6'(GRAVITY);
    localparam logic signed [10:0] Y_FLOOR = 11'(SCREEN_H - BIRD_SIZE);

    game_state_t        st;
    logic signed [5:0]  vel, vel_grav, vel_next;
    logic signed [10:0] y_next;
    logic [CNT_W-1:0]   cnt;
    logic               flap_d, flap_ev, ground, hit_any, y_neg, y_floor;
    logic [NUM_TUBES-1:0][9:0] tube_x, tube_y;
    logic [NUM_TUBES-1:0]      tube_hits;

    assign tube_x = {tube3_x_pos, tube2_x_pos, tube1_x_pos};
    assign tube_y = {tube3_y_pos, tube2_y_pos, tube1_y_pos};

    for (genvar gi = 0; gi < NUM_TUBES; gi++) begin : g_tube
        tube_hit #(.BIRD_X(BIRD_X), .BIRD_SIZE(BIRD_SIZE)) u_hit (
            .x_pos (tube_x[gi]),
            .y_pos (tube_y[gi]),
            .bird_y(bird_y),
            .hit   (tube_hits[gi])
        );
    end

    assign flap_ev = flap & ~flap_d;
    assign ground  = ({1'b0, bird_y} + 11'(BIRD_SIZE)) >= 11'(SCREEN_H);
    assign hit_any = (|tube_hits) | ground;

    // A hit wins over a same-tick flap: the bird only gets gravity.
    always_comb begin
        vel_grav = (vel >= VMAX_V) ? VMAX_V : vel + GRAV_V;
        vel_next = (st == ST_PLAY && flap_ev && !hit_any) ? FLAP_V : vel_grav;
        y_next   = $signed({1'b0, bird_y}) + {{5{vel_next[5]}}, vel_next};
        y_neg    = y_next < 0;
        y_floor  = y_next >= Y_FLOOR;
    end

    assign state = st;

    always_ff @(posedge clk10 or negedge clr_n) begin
        if (!clr_n) begin
            st         <= ST_IDLE;
            bird_y     <= 10'(Y_START);
            vel        <= '0;
            collide    <= 1'b0;
            tubes_run  <= 1'b0;
            best_score <= '0;
            flap_d     <= 1'b0;
            cnt        <= '0;
        end else begin
            flap_d <= flap;
            case (st)
                ST_IDLE: begin
                    bird_y <= 10'(Y_START);
                    vel    <= '0;
                    if (flap_ev) begin
                        st        <= ST_PLAY;
                        vel       <= FLAP_V;
                        bird_y    <= 10'(Y_START + FLAP_VEL);
                        tubes_run <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    vel    <= y_neg ? 6'sd0 : vel_next;
                    bird_y <= y_neg ? 10'd0 : y_next[9:0];
                    if (hit_any) begin
                        st        <= ST_DYING;
                        collide   <= 1'b1;
                        tubes_run <= 1'b0;
                        cnt       <= CNT_W'(DEATH_TICKS);
                    end
                end
                ST_DYING: begin
                    vel <= y_neg ? 6'sd0 : vel_next;
                    if (y_neg)        bird_y <= 10'd0;
                    else if (y_floor) bird_y <= 10'(SCREEN_H - BIRD_SIZE);
                    else              bird_y <= y_next[9:0];
                    if (y_floor || cnt <= CNT_W'(1)) begin
                        st  <= ST_OVER;
                        cnt <= '0;
                        if (score > best_score) best_score <= score;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_OVER: begin
                    if (flap_ev) begin
                        st      <= ST_IDLE;
                        bird_y  <= 10'(Y_START);
                        vel     <= '0;
                        collide <= 1'b0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bird_game_ctrl.sv
// Directed checks of bird physics, collisions, DYING timeout and best score.
module tb_bird_game_ctrl;
    logic       clk10 = 1'b0;
    logic       clr_n = 1'b0;
    logic       flap  = 1'b0;
    logic [9:0] tube1_x_pos = 10'd600, tube2_x_pos = 10'd600, tube3_x_pos = 10'd600;
    logic [9:0] tube1_y_pos = 10'd0,   tube2_y_pos = 10'd0,   tube3_y_pos = 10'd0;
    logic [7:0] score = 8'd0;
    logic [9:0] bird_y;
    logic [1:0] state;
    logic       collide, tubes_run;
    logic [7:0] best_score;

    int n_chk  = 0;
    int n_fail = 0;

    bird_game_ctrl dut (
        .clk10      (clk10),
        .clr_n      (clr_n),
        .flap       (flap),
        .tube1_x_pos(tube1_x_pos),
        .tube2_x_pos(tube2_x_pos),
        .tube3_x_pos(tube3_x_pos),
        .tube1_y_pos(tube1_y_pos),
        .tube2_y_pos(tube2_y_pos),
        .tube3_y_pos(tube3_y_pos),
        .score      (score),
        .bird_y     (bird_y),
        .state      (state),
        .collide    (collide),
        .tubes_run  (tubes_run),
        .best_score (best_score)
    );

    always #5 clk10 = ~clk10;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk10);
        @(negedge clk10);
    endtask

    int exp_y[11] = '{207, 205, 204, 204, 205, 207, 210, 214, 219, 225, 232};
    int hold_y[4] = '{225, 219, 214, 210};

    initial begin
        // reset held for two ticks
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_bird_y", bird_y, 240);
        chk("rst_collide", collide, 0);
        chk("rst_run", tubes_run, 0);
        chk("rst_best", best_score, 0);
        clr_n = 1'b1;
        tick(10);
        chk("idle_state", state, 0);
        chk("idle_bird_y", bird_y, 240);
        chk("idle_run", tubes_run, 0);
        chk("idle_best", best_score, 0);

        // start; flap held five ticks gives a single flap
        flap = 1'b1;
        tick(1);
        chk("start_state", state, 1);
        chk("start_bird_y", bird_y, 232);
        chk("start_run", tubes_run, 1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk($sformatf("hold_y%0d", i), bird_y, hold_y[i]);
        end
        flap = 1'b0;

        // bird passes through the gap of tube1
        tube1_x_pos = 10'd150; tube1_y_pos = 10'd200;
        for (int i = 0; i < 11; i++) begin
            tick(1);
            chk($sformatf("gap_y%0d", i), bird_y, exp_y[i]);
            chk($sformatf("gap_col%0d", i), collide, 0);
        end

        // gap moved below the bird: hit
        tube1_y_pos = 10'd300; score = 8'd7;
        tick(1);
        chk("hit_state", state, 2);
        chk("hit_collide", collide, 1);
        chk("hit_run", tubes_run, 0);
        chk("hit_bird_y", bird_y, 240);
        tick(19);
        chk("dying19_state", state, 2);
        chk("dying19_y", bird_y, 429);
        tick(1);
        chk("timeout_state", state, 3);
        chk("timeout_y", bird_y, 439);
        chk("best7", best_score, 7);
        tick(3);
        chk("over_frozen_y", bird_y, 439);
        chk("over_state", state, 3);

        // flap in OVER returns to IDLE; held button does not restart
        flap = 1'b1;
        tick(1);
        chk("restart_state", state, 0);
        chk("restart_y", bird_y, 240);
        chk("restart_col", collide, 0);
        tick(3);
        chk("held_no_start", state, 0);
        flap = 1'b0;
        tick(1);

        // game 2: fall to the ground with score 3
        tube1_x_pos = 10'd600; score = 8'd3;
        flap = 1'b1;
        tick(1);
        chk("g2_state", state, 1);
        flap = 1'b0;
        begin
            int k;
            k = 0;
            while (state != 2'd3 && k < 60) begin
                tick(1);
                k++;
            end
        end
        chk("ground_over", state, 3);
        chk("ground_y", bird_y, 464);
        chk("ground_col", collide, 1);
        chk("best_kept", best_score, 7);

        // game 3: hit and flap on the same tick
        flap = 1'b1; tick(1);
        chk("g3_idle", state, 0);
        flap = 1'b0; tick(1);
        flap = 1'b1; tick(1);
        chk("g3_play_y", bird_y, 232);
        flap = 1'b0; tick(1);
        chk("g3_y225", bird_y, 225);
        tube1_x_pos = 10'd150; tube1_y_pos = 10'd300; flap = 1'b1;
        tick(1);
        chk("simul_state", state, 2);
        chk("simul_y", bird_y, 219);

        // asynchronous reset in DYING, away from any clock edge
        #2 clr_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_y", bird_y, 240);
        chk("arst_col", collide, 0);
        chk("arst_run", tubes_run, 0);
        chk("arst_best", best_score, 0);
        flap = 1'b0;
        tick(1);
        clr_n = 1'b1;
        tick(2);
        chk("post_rst_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
